adpll_lock_controller: RTL and testbench

- Sequences ADPLL frequency acquisition from the phase-frequency detector's UP/DN flags.
- Integrates UP/DN over fixed windows of clk cycles.
- Steps the DCO control word coarsely, then finely, and declares lock.
- Sits between the PFD and the DCO; drives the tuning word and the lock status seen by system control.

---
 rtl/adpll_pkg.sv | 22 ++
 rtl/adpll_lock_controller_if.sv | 27 ++
 rtl/adpll_err_window.sv | 48 ++++
 rtl/adpll_lock_controller.sv | 151 +++++++++++++++
 tb/tb_adpll_lock_controller.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/adpll_pkg.sv
// Shared state/direction encodings and a counter-width helper for the ADPLL lock controller.
package adpll_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COARSE = 2'd1,
        FINE   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/adpll_lock_controller_if.sv
// PFD-side inputs and DCO/status outputs of the lock controller; slave is the controller's view.
interface adpll_lock_controller_if #(
    parameter int CW_W    = 10,
    parameter int WIN_LEN = 16
);
    localparam int ERR_W = adpll_pkg::cnt_w(WIN_LEN) + 1;

    logic                    enable;
    logic                    up;
    logic                    dn;
    logic [CW_W-1:0]         dco_word;
    logic                    locked;
    logic [1:0]              state;
    logic                    win_done;
    logic signed [ERR_W-1:0] freq_err;

    modport master (
        output enable, up, dn,
        input  dco_word, locked, state, win_done, freq_err
    );

    modport slave (
        input  enable, up, dn,
        output dco_word, locked, state, win_done, freq_err
    );

endinterface

// File: rtl/adpll_err_window.sv
// Integrates PFD up/dn over WIN_LEN-cycle windows; eval/diff are combinational on the last sample.
// No backpressure: one sample per clk, counters cleared whenever run is low.
module adpll_err_window import adpll_pkg::*; #(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = cnt_w(WIN_LEN),
    parameter int ERR_W   = CNT_W + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    up,
    input  logic                    dn,
    output logic                    eval,
    output logic signed [ERR_W-1:0] diff
);
    localparam int WIN_W = cnt_w(WIN_LEN - 1);

    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] up_cnt;
    logic [CNT_W-1:0] dn_cnt;
    logic [CNT_W-1:0] up_tot;
    logic [CNT_W-1:0] dn_tot;

    // Totals fold in the current sample so the last cycle of a window is counted.
    always_comb begin
        up_tot = up_cnt + CNT_W'(up & ~dn);
        dn_tot = dn_cnt + CNT_W'(dn & ~up);
        eval   = run && (win_cnt == WIN_W'(WIN_LEN - 1));
        diff   = $signed({1'b0, up_tot}) - $signed({1'b0, dn_tot});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt <= '0;
            up_cnt  <= '0;
            dn_cnt  <= '0;
        end else if (!run || eval) begin
            win_cnt <= '0;
            up_cnt  <= '0;
            dn_cnt  <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            up_cnt  <= up_tot;
            dn_cnt  <= dn_tot;
        end
    end

endmodule

// File: rtl/adpll_lock_controller.sv
// ADPLL acquisition FSM: coarse then fine DCO stepping per window, lock declare/drop; word updates 1 clk after a window's last sample.
// No backpressure. ADPLL_WARM_START_EN keeps dco_word when enable drops instead of reloading CW_INIT.
module adpll_lock_controller import adpll_pkg::*; #(
    parameter int CW_W        = 10,
    parameter int CW_INIT     = 512,
    parameter int WIN_LEN     = 16,
    parameter int COARSE_STEP = 16,
    parameter int FINE_STEP   = 1,
    parameter int REV_CNT     = 2,
    parameter int LOCK_TOL    = 1,
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_TOL  = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    adpll_lock_controller_if.slave  bus
);
    localparam int CNT_W = cnt_w(WIN_LEN);
    localparam int ERR_W = CNT_W + 1;
    localparam int REV_W = cnt_w(REV_CNT);
    localparam int QCT_W = cnt_w(LOCK_CNT);
    localparam logic [CW_W:0] C_STEP = (CW_W + 1)'(COARSE_STEP);
    localparam logic [CW_W:0] F_STEP = (CW_W + 1)'(FINE_STEP);
    localparam logic [CW_W:0] W_MAX  = {1'b0, {CW_W{1'b1}}};

    state_t                  state_q;
    dir_t                    last_dir;
    dir_t                    dir_now;
    logic [REV_W-1:0]        rev_cnt;
    logic [QCT_W-1:0]        quiet_cnt;
    logic [CW_W-1:0]         dco_word_q;
    logic [CW_W-1:0]         word_nxt;
    logic                    locked_q;
    logic                    win_done_q;
    logic signed [ERR_W-1:0] freq_err_q;
    logic                    eval;
    logic signed [ERR_W-1:0] diff;
    logic [CW_W:0]           step;
    logic [CW_W:0]           word_ext;
    logic [CW_W:0]           sum_up;
    int                      diff_i;
    int                      abs_i;
    logic                    rev_hit;
    logic                    quiet;

    adpll_err_window #(
        .WIN_LEN (WIN_LEN),
        .CNT_W   (CNT_W),
        .ERR_W   (ERR_W)
    ) u_win (
        .clk   (clk),
        .reset (reset),
        .run   (bus.enable && (state_q != IDLE)),
        .up    (bus.up),
        .dn    (bus.dn),
        .eval  (eval),
        .diff  (diff)
    );

    // Saturating word update; clamping never feeds back into reversal/quiet accounting.
    always_comb begin
        step     = (state_q == COARSE) ? C_STEP : F_STEP;
        word_ext = {1'b0, dco_word_q};
        sum_up   = word_ext + step;
        word_nxt = dco_word_q;
        if (diff > 0)
            word_nxt = (sum_up > W_MAX) ? {CW_W{1'b1}} : sum_up[CW_W-1:0];
        else if (diff < 0)
            word_nxt = (word_ext < step) ? '0 : dco_word_q - step[CW_W-1:0];

        diff_i  = int'(diff);
        abs_i   = (diff_i < 0) ? -diff_i : diff_i;
        quiet   = (abs_i <= LOCK_TOL);
        dir_now = (diff > 0) ? DIR_UP : ((diff < 0) ? DIR_DN : DIR_NONE);
        rev_hit = (last_dir != DIR_NONE) && (dir_now != DIR_NONE) && (dir_now != last_dir);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_dir   <= DIR_NONE;
            rev_cnt    <= '0;
            quiet_cnt  <= '0;
            dco_word_q <= CW_W'(CW_INIT);
            locked_q   <= 1'b0;
            win_done_q <= 1'b0;
            freq_err_q <= '0;
        end else begin
            win_done_q <= 1'b0;
            if (!bus.enable) begin
                state_q   <= IDLE;
                locked_q  <= 1'b0;
                last_dir  <= DIR_NONE;
                rev_cnt   <= '0;
                quiet_cnt <= '0;
`ifndef ADPLL_WARM_START_EN
                dco_word_q <= CW_W'(CW_INIT);
`endif
            end else if (state_q == IDLE) begin
                state_q <= COARSE;
            end else if (eval) begin
                win_done_q <= 1'b1;
                freq_err_q <= diff;
                dco_word_q <= word_nxt;
                case (state_q)
                    COARSE: begin
                        if (rev_hit) begin
                            if (rev_cnt == REV_W'(REV_CNT - 1)) begin
                                state_q  <= FINE;
                                rev_cnt  <= '0;
                                last_dir <= DIR_NONE;
                            end else begin
                                rev_cnt  <= rev_cnt + 1'b1;
                                last_dir <= dir_now;
                            end
                        end else if (dir_now != DIR_NONE) begin
                            last_dir <= dir_now;
                        end
                    end
                    FINE: begin
                        if (!quiet) begin
                            quiet_cnt <= '0;
                        end else if (quiet_cnt == QCT_W'(LOCK_CNT - 1)) begin
                            state_q   <= LOCKED;
                            locked_q  <= 1'b1;
                            quiet_cnt <= '0;
                        end else begin
                            quiet_cnt <= quiet_cnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (abs_i > UNLOCK_TOL) begin
                            state_q   <= COARSE;
                            locked_q  <= 1'b0;
                            quiet_cnt <= '0;
                            rev_cnt   <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.dco_word = dco_word_q;
    assign bus.locked   = locked_q;
    assign bus.state    = state_q;
    assign bus.win_done = win_done_q;
    assign bus.freq_err = freq_err_q;

endmodule

// File: tb/tb_adpll_lock_controller.sv
// Bench for adpll_lock_controller: window results queued at stimulus time, compared when win_done pulses.
module tb_adpll_lock_controller;

    typedef struct {
        int word;
        int st;
        int lk;
        int fe;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q1[$];
    exp_t q2[$];
    int   exp_drop_word;

    adpll_lock_controller_if #(.CW_W(10), .WIN_LEN(16)) b1 ();
    adpll_lock_controller_if #(.CW_W(10), .WIN_LEN(16)) b2 ();

    adpll_lock_controller #(.CW_INIT(512)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.slave)
    );

    adpll_lock_controller #(.CW_INIT(1020)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push1(input int w, input int s, input int l, input int f);
        exp_t e;
        e.word = w; e.st = s; e.lk = l; e.fe = f;
        q1.push_back(e);
    endtask

    task automatic push2(input int w, input int s, input int l, input int f);
        exp_t e;
        e.word = w; e.st = s; e.lk = l; e.fe = f;
        q2.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full window: ups up-only cycles, then dns dn-only, then boths both-high, rest idle.
    task automatic drive_window(input int ups, input int dns, input int boths);
        for (int i = 0; i < 16; i++) begin
            logic u, d;
            u = (i < ups) || (i >= ups + dns && i < ups + dns + boths);
            d = (i >= ups && i < ups + dns + boths);
            b1.up = u; b1.dn = d;
            b2.up = u; b2.dn = d;
            tick();
        end
        b1.up = 1'b0; b1.dn = 1'b0;
        b2.up = 1'b0; b2.dn = 1'b0;
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (!reset && b1.win_done === 1'b1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_win_done", 1, 0);
            end else begin
                e = q1.pop_front();
                check("dut1_dco_word", int'(b1.dco_word), e.word);
                check("dut1_state", int'(b1.state), e.st);
                check("dut1_locked", int'(b1.locked), e.lk);
                check("dut1_freq_err", int'(b1.freq_err), e.fe);
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (!reset && b2.win_done === 1'b1) begin
            if (q2.size() == 0) begin
                check("dut2_unexpected_win_done", 1, 0);
            end else begin
                e = q2.pop_front();
                check("dut2_dco_word", int'(b2.dco_word), e.word);
                check("dut2_state", int'(b2.state), e.st);
                check("dut2_locked", int'(b2.locked), e.lk);
                check("dut2_freq_err", int'(b2.freq_err), e.fe);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        b1.enable = 1'b0; b1.up = 1'b0; b1.dn = 1'b0;
        b2.enable = 1'b0; b2.up = 1'b0; b2.dn = 1'b0;
        repeat (3) tick();

        check("rst_dco_word", int'(b1.dco_word), 512);
        check("rst_locked", int'(b1.locked), 0);
        check("rst_state", int'(b1.state), 0);
        check("rst_win_done", int'(b1.win_done), 0);
        check("rst_freq_err", int'(b1.freq_err), 0);
        check("rst_dut2_word", int'(b2.dco_word), 1020);

        reset = 1'b0;
        tick();
        check("idle_hold_state", int'(b1.state), 0);

        b1.enable = 1'b1;
        tick();
        check("enter_coarse_state", int'(b1.state), 1);

        // Coarse acquisition with two reversals, including a both-high window.
        push1(528, 1, 0, 16);   drive_window(16, 0, 0);
        push1(528, 1, 0, 0);    drive_window(0, 0, 16);
        push1(512, 1, 0, -16);  drive_window(0, 16, 0);
        push1(528, 2, 0, 16);   drive_window(16, 0, 0);

        // Fine: four quiet windows reach lock on the fourth.
        push1(529, 2, 0, 1);    drive_window(1, 0, 0);
        push1(530, 2, 0, 1);    drive_window(1, 0, 0);
        push1(531, 2, 0, 1);    drive_window(1, 0, 0);
        push1(532, 3, 1, 1);    drive_window(1, 0, 0);

        // Large error in LOCKED: fine step applied, then back to COARSE.
        push1(533, 1, 0, 10);   drive_window(10, 0, 0);

        // Asynchronous reset partway through a window.
        b1.up = 1'b1;
        repeat (5) tick();
        #3 reset = 1'b1;
        #1;
        check("midrst_dco_word", int'(b1.dco_word), 512);
        check("midrst_locked", int'(b1.locked), 0);
        check("midrst_state", int'(b1.state), 0);
        check("midrst_win_done", int'(b1.win_done), 0);
        check("midrst_freq_err", int'(b1.freq_err), 0);
        b1.up = 1'b0;
        b1.enable = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Clamp at the top of the word range, then drop enable mid-window.
        b2.enable = 1'b1;
        tick();
        check("dut2_enter_coarse", int'(b2.state), 1);
        push2(1023, 1, 0, 16);  drive_window(16, 0, 0);
        push2(1023, 1, 0, 16);  drive_window(16, 0, 0);

        b2.up = 1'b1;
        repeat (7) tick();
        b2.enable = 1'b0;
        tick();
`ifdef ADPLL_WARM_START_EN
        exp_drop_word = 1023;
`else
        exp_drop_word = 1020;
`endif
        check("drop_state", int'(b2.state), 0);
        check("drop_locked", int'(b2.locked), 0);
        check("drop_win_done", int'(b2.win_done), 0);
        check("drop_dco_word", int'(b2.dco_word), exp_drop_word);
        b2.up = 1'b0;

        repeat (20) tick();
        check("drop_idle_state", int'(b2.state), 0);
        check("drop_idle_word", int'(b2.dco_word), exp_drop_word);
        check("q1_pending", q1.size(), 0);
        check("q2_pending", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
